spi_master_multi_cs: RTL and testbench

//  Parametrised SPI master, successor to the fixed-mode master in spi_top.

---
 rtl/spi_master_multi_cs_if.sv | 42 ++++
 rtl/spi_master_multi_cs.sv | 235 +++++++++++++++++++++++
 tb/tb_spi_master_multi_cs.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_multi_cs_if.sv
`timescale 1ns/1ps
// spi_master_multi_cs_if
//   System-side request/response bundle for spi_master_multi_cs.
//   master modport: request logic (drives start/req/spi_mode/cs_sel/
//                   wait_duration/din, observes dout/busy/done_tx/done_rx)
//   slave modport : the SPI master itself (the reverse directions)
//   start          1-cycle request strobe
//   req            0 none, 1 tx, 2 rx, 3 full duplex
//   spi_mode       [1]=CPOL, [0]=CPHA
//   cs_sel         chip-select index
//   wait_duration  post-frame gap in clk cycles
//   din / dout     transmit frame / last received frame
//   busy           transfer in progress
//   done_tx/rx     1-cycle completion pulses
interface spi_master_multi_cs_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int WAIT_W = 8
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic              start;
  logic [1:0]        req;
  logic [1:0]        spi_mode;
  logic [CS_W-1:0]   cs_sel;
  logic [WAIT_W-1:0] wait_duration;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              busy;
  logic              done_tx;
  logic              done_rx;

  modport master (
    output start, req, spi_mode, cs_sel, wait_duration, din,
    input  dout, busy, done_tx, done_rx
  );

  modport slave (
    input  start, req, spi_mode, cs_sel, wait_duration, din,
    output dout, busy, done_tx, done_rx
  );
endinterface

// File: rtl/spi_master_multi_cs.sv
`timescale 1ns/1ps
// spi_master_multi_cs
//   SPI master with per-transfer mode (CPOL/CPHA), DATA_W-bit MSB-first
//   frames, NUM_CS chip selects, tx/rx/full-duplex requests and a
//   programmable post-frame gap.
//   Frame sequence: IDLE -> SETUP -> SHIFT -> HOLD -> WAIT -> IDLE.
//   Ports:
//     clk      system clock (posedge)
//     rst_n    asynchronous active-low reset
//     bus      request/response bundle (spi_master_multi_cs_if.slave)
//     sclk     SPI clock, idles at the CPOL of the last accepted request
//     mosi     master out (held 0 when the request has no tx part)
//     miso     master in
//     cs_n     active-low chip selects, at most one low
//     loopback (only with SPI_LOOPBACK_EN) sample mosi instead of miso and
//              keep every cs_n high for the frame
//   Optional feature macro: SPI_LOOPBACK_EN
module spi_master_multi_cs #(
  parameter int DATA_W  = 8,
  parameter int NUM_CS  = 4,
  parameter int CLK_DIV = 28,
  parameter int WAIT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_master_multi_cs_if.slave bus,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso,
`ifdef SPI_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic [NUM_CS-1:0]    cs_n
);

  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int EDGE_W = $clog2(2 * DATA_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_WAIT
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] tx_sr_r;
  logic [DATA_W-1:0] rx_sr_r;
  logic [DATA_W-1:0] dout_r;
  logic [1:0]        req_r;
  logic              cpol_r;
  logic              cpha_r;
  logic [CS_W-1:0]   cs_sel_r;
  logic [WAIT_W-1:0] wait_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic [EDGE_W-1:0] edge_cnt_r;
  logic              busy_r;
  logic              done_tx_r;
  logic              done_rx_r;
  logic              sclk_r;
  logic              mosi_r;
  logic [NUM_CS-1:0] cs_n_r;

  logic              accept_s;
  logic              sample_s;
  logic              cs_off_s;
  logic [NUM_CS-1:0] cs_low_s;

  // Request acceptance: only from IDLE, with a real request and a valid select.
  assign accept_s = (state_r == ST_IDLE) && bus.start && (bus.req != 2'b00) &&
                    (32'(bus.cs_sel) < NUM_CS);

`ifdef SPI_LOOPBACK_EN
  logic lb_r;

  // Loopback selection is captured with the rest of the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_r <= 1'b0;
    end else if (accept_s) begin
      lb_r <= loopback;
    end
  end

  assign sample_s = lb_r ? mosi_r : miso;
  assign cs_off_s = lb_r;
`else
  assign sample_s = miso;
  assign cs_off_s = 1'b0;
`endif

  // Chip-select pattern driven while a frame is on the wire.
  always_comb begin
    cs_low_s = {NUM_CS{1'b1}};
    if (cs_off_s) begin
      cs_low_s = {NUM_CS{1'b1}};
    end else begin
      cs_low_s[cs_sel_r] = 1'b0;
    end
  end

  // Transfer FSM with all pin and handshake outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      tx_sr_r    <= '0;
      rx_sr_r    <= '0;
      dout_r     <= '0;
      req_r      <= 2'b00;
      cpol_r     <= 1'b0;
      cpha_r     <= 1'b0;
      cs_sel_r   <= '0;
      wait_r     <= '0;
      wait_cnt_r <= '0;
      div_cnt_r  <= '0;
      edge_cnt_r <= '0;
      busy_r     <= 1'b0;
      done_tx_r  <= 1'b0;
      done_rx_r  <= 1'b0;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      cs_n_r     <= {NUM_CS{1'b1}};
    end else begin
      done_tx_r <= 1'b0;
      done_rx_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            tx_sr_r    <= bus.din;
            req_r      <= bus.req;
            cpol_r     <= bus.spi_mode[1];
            cpha_r     <= bus.spi_mode[0];
            cs_sel_r   <= bus.cs_sel;
            wait_r     <= bus.wait_duration;
            sclk_r     <= bus.spi_mode[1];
            busy_r     <= 1'b1;
            div_cnt_r  <= '0;
            edge_cnt_r <= '0;
            state_r    <= ST_SETUP;
          end else begin
            sclk_r <= cpol_r;
          end
        end

        // cs_n goes low on the first SETUP cycle; the counter runs to CLK_DIV
        // so the select is asserted for CLK_DIV cycles before SHIFT starts.
        ST_SETUP: begin
          cs_n_r <= cs_low_s;
          if (!cpha_r && req_r[0]) begin
            mosi_r <= tx_sr_r[DATA_W-1];
          end
          if (div_cnt_r == DIV_W'(CLK_DIV)) begin
            div_cnt_r <= '0;
            state_r   <= ST_SHIFT;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end

        // Even edge indices are leading edges (CPOL -> !CPOL).
        ST_SHIFT: begin
          if (div_cnt_r == DIV_W'(CLK_DIV - 1)) begin
            div_cnt_r <= '0;
            sclk_r    <= ~sclk_r;
            if (edge_cnt_r[0] == cpha_r) begin
              rx_sr_r <= {rx_sr_r[DATA_W-2:0], sample_s};
            end else begin
              // CPHA=1 presents the current MSB; CPHA=0 already showed it in SETUP.
              if (req_r[0]) begin
                mosi_r <= cpha_r ? tx_sr_r[DATA_W-1] : tx_sr_r[DATA_W-2];
              end
              tx_sr_r <= tx_sr_r << 1;
            end
            if (edge_cnt_r == EDGE_W'(2 * DATA_W - 1)) begin
              state_r <= ST_HOLD;
            end else begin
              edge_cnt_r <= edge_cnt_r + EDGE_W'(1);
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end

        ST_HOLD: begin
          if (div_cnt_r == DIV_W'(CLK_DIV - 1)) begin
            div_cnt_r  <= '0;
            wait_cnt_r <= '0;
            cs_n_r     <= {NUM_CS{1'b1}};
            mosi_r     <= 1'b0;
            done_tx_r  <= req_r[0];
            done_rx_r  <= req_r[1];
            if (req_r[1]) begin
              dout_r <= rx_sr_r;
            end
            if (wait_r == '0) begin
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_WAIT;
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end

        ST_WAIT: begin
          if (wait_cnt_r == wait_r - WAIT_W'(1)) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end
        end

        default: begin
          busy_r  <= 1'b0;
          cs_n_r  <= {NUM_CS{1'b1}};
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign sclk        = sclk_r;
  assign mosi        = mosi_r;
  assign cs_n        = cs_n_r;
  assign bus.dout    = dout_r;
  assign bus.busy    = busy_r;
  assign bus.done_tx = done_tx_r;
  assign bus.done_rx = done_rx_r;

endmodule

// File: tb/tb_spi_master_multi_cs.sv
`timescale 1ns/1ps
// tb_spi_master_multi_cs
//   Directed and randomized frames against a behavioural SPI slave that
//   reacts to sclk edges according to the selected mode. Expected frames,
//   dout, latency, gap length and chip-select pattern are computed here.
//   NUM_CS=3 so that an out-of-range cs_sel can be requested.
module tb_spi_master_multi_cs;
  localparam int NUM_CS  = 3;
  localparam int LATENCY = 28 * (2 * 8 + 2) + 1;

  logic clk;
  logic rst_n;
  logic sclk;
  logic mosi;
  logic miso;
  logic loopback;
  logic [NUM_CS-1:0] cs_n;

  spi_master_multi_cs_if #(.DATA_W(8), .NUM_CS(NUM_CS), .WAIT_W(8)) bus ();

  spi_master_multi_cs #(.DATA_W(8), .NUM_CS(NUM_CS), .CLK_DIV(28), .WAIT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .sclk(sclk),
    .mosi(mosi),
    .miso(miso),
`ifdef SPI_LOOPBACK_EN
    .loopback(loopback),
`endif
    .cs_n(cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Slave model state, written only by the monitor process.
  logic [7:0]        slave_word = 8'h00;
  logic [1:0]        mode_cur = 2'b00;
  logic [7:0]        mon_rx;
  int                mon_samples;
  int                mon_edges;
  int                sh_cnt;
  logic [NUM_CS-1:0] cs_and;
  bit                cs_multi;
  bit                mosi_hi;
  logic              prev_sclk;
  logic              prev_busy;
  logic [7:0]        dout_model = 8'h00;

  function automatic logic slave_bit(input logic [7:0] w, input int n, input logic cpha);
    int idx;
    idx = cpha ? 8 - n : 7 - n;
    if (idx >= 0 && idx <= 7) return w[idx];
    return 1'b0;
  endfunction

  assign miso = slave_bit(slave_word, sh_cnt, mode_cur[0]);

  // Slave: samples mosi on its sample edge, advances miso on its shift edge.
  always @(negedge clk) begin
    prev_sclk <= sclk;
    prev_busy <= bus.busy;
    if (bus.busy && !prev_busy) begin
      mon_rx      <= 8'h00;
      mon_samples <= 0;
      mon_edges   <= 0;
      sh_cnt      <= 0;
      cs_and      <= '1;
      cs_multi    <= 1'b0;
      mosi_hi     <= 1'b0;
    end else begin
      if (bus.busy) cs_and <= cs_and & cs_n;
      if ($countones(~cs_n) > 1) cs_multi <= 1'b1;
      if (bus.busy && mosi) mosi_hi <= 1'b1;
      if (sclk !== prev_sclk) begin
        mon_edges <= mon_edges + 1;
        if ((prev_sclk == mode_cur[1]) != mode_cur[0]) begin
          mon_rx      <= {mon_rx[6:0], mosi};
          mon_samples <= mon_samples + 1;
        end else begin
          sh_cnt <= sh_cnt + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [1:0] rq, input logic [1:0] md, input logic [1:0] cs,
                      input logic [7:0] wt, input logic [7:0] d, input logic lb);
    @(negedge clk);
    bus.start = 1'b1; bus.req = rq; bus.spi_mode = md; bus.cs_sel = cs;
    bus.wait_duration = wt; bus.din = d; loopback = lb;
    @(negedge clk);
    bus.start = 1'b0;
    // Scramble inputs: they must have no effect on the running frame.
    bus.din = ~d; bus.spi_mode = ~md; bus.cs_sel = cs ^ 2'b01;
    bus.wait_duration = wt + 8'd5; loopback = ~lb;
  endtask

  task automatic do_frame(input string nm, input logic [1:0] rq, input logic [1:0] md,
                          input logic [1:0] cs, input logic [7:0] wt, input logic [7:0] d,
                          input logic [7:0] sw, input logic lb, input bit mid_start);
    int k;
    int bw;
    logic [NUM_CS-1:0] cs_exp;
    slave_word = sw;
    mode_cur   = md;
    kick(rq, md, cs, wt, d, lb);
    k = 0;
    while (!(bus.done_tx || bus.done_rx) && k < 1000) begin
      @(negedge clk);
      k++;
      bus.start = (mid_start && k == 100);
      if (k < LATENCY) begin
        if (bus.busy !== 1'b1) check({nm, "_busy_mid"}, bus.busy, 1'b1);
      end
    end
    check({nm, "_latency"}, k, LATENCY);
    check({nm, "_done_tx"}, bus.done_tx, rq[0]);
    check({nm, "_done_rx"}, bus.done_rx, rq[1]);
    check({nm, "_cs_release"}, cs_n, {NUM_CS{1'b1}});
    check({nm, "_sclk_idle"}, sclk, md[1]);
    if (rq[1]) dout_model = lb ? d : sw;
    check({nm, "_dout"}, bus.dout, dout_model);
    check({nm, "_slave_rx"}, mon_rx, rq[0] ? d : 8'h00);
    check({nm, "_samples"}, mon_samples, 8);
    check({nm, "_sclk_edges"}, mon_edges, 16);
    cs_exp = {NUM_CS{1'b1}};
    if (!lb) cs_exp[cs] = 1'b0;
    check({nm, "_cs_pattern"}, cs_and, cs_exp);
    check({nm, "_cs_onehot"}, cs_multi, 1'b0);
    if (!rq[0]) check({nm, "_mosi_quiet"}, mosi_hi, 1'b0);
    bw = 0;
    while (bus.busy && bw < 300) begin
      @(negedge clk);
      bw++;
    end
    check({nm, "_gap"}, bw, wt);
    @(negedge clk);
    check({nm, "_pulse_len"}, {bus.done_tx, bus.done_rx}, 2'b00);
    repeat (3) @(negedge clk);
    check({nm, "_idle_busy"}, bus.busy, 1'b0);
    check({nm, "_idle_cs"}, cs_n, {NUM_CS{1'b1}});
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int dcnt;
    logic [1:0] r_rq, r_md, r_cs;
    logic [7:0] r_wt, r_d, r_sw;

    bus.start = 1'b0; bus.req = 2'b00; bus.spi_mode = 2'b00; bus.cs_sel = 2'b00;
    bus.wait_duration = 8'd0; bus.din = 8'h00; loopback = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_cs", cs_n, {NUM_CS{1'b1}});
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", {bus.done_tx, bus.done_rx}, 2'b00);
    check("rst_dout", bus.dout, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: mode 0 transmit only on select 2.
    do_frame("t1", 2'd1, 2'd0, 2'd2, 8'd0, 8'hA5, 8'hFF, 1'b0, 1'b0);

    // T2: receive only in modes 1..3.
    for (int m = 1; m < 4; m++) begin
      do_frame("t2", 2'd2, 2'(m), 2'(m - 1), 8'd0, 8'hFF, 8'h3C, 1'b0, 1'b0);
    end

    // Mode change while idle must not move sclk before the next accept.
    bus.spi_mode = 2'b00;
    repeat (5) @(negedge clk);
    check("idle_mode_hold", sclk, 1'b1);

    // T3: full duplex with gap and an ignored start while busy.
    do_frame("t3", 2'd3, 2'd0, 2'd1, 8'd10, 8'hC3, 8'h5A, 1'b0, 1'b1);

    // T5: requests that must be ignored.
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.req = (v == 0) ? 2'd0 : 2'd3;
      bus.cs_sel = (v == 0) ? 2'd0 : 2'd3;
      @(negedge clk);
      bus.start = 1'b0;
      dcnt = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (bus.busy || bus.done_tx || bus.done_rx || cs_n != {NUM_CS{1'b1}}) dcnt++;
      end
      check(v == 0 ? "t5_req0" : "t5_bad_cs", dcnt, 0);
    end

    // T4: asynchronous reset in the middle of a frame.
    slave_word = 8'h81;
    mode_cur   = 2'b01;
    kick(2'd3, 2'd1, 2'd0, 8'd3, 8'h7E, 1'b0);
    k = 0;
    while (mon_edges < 4 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("t4_reach_edges", k < 2000, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t4_cs", cs_n, {NUM_CS{1'b1}});
    check("t4_sclk", sclk, 1'b0);
    check("t4_busy", bus.busy, 1'b0);
    dout_model = 8'h00;
    dcnt = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (c == 5) rst_n = 1'b1;
      if (bus.done_tx || bus.done_rx || bus.busy) dcnt++;
    end
    check("t4_no_done", dcnt, 0);
    check("t4_dout", bus.dout, 8'h00);
    do_frame("t4_after", 2'd3, 2'd2, 2'd2, 8'd2, 8'h1F, 8'hE4, 1'b0, 1'b0);

    // Randomized frames.
    for (int i = 0; i < 6; i++) begin
      r_rq = 2'($urandom_range(1, 3));
      r_md = 2'($urandom_range(0, 3));
      r_cs = 2'($urandom_range(0, NUM_CS - 1));
      r_wt = 8'($urandom_range(0, 6));
      r_d  = 8'($urandom);
      r_sw = 8'($urandom);
      do_frame("rnd", r_rq, r_md, r_cs, r_wt, r_d, r_sw, 1'b0, 1'b0);
    end

`ifdef SPI_LOOPBACK_EN
    // T6: loopback full duplex, all selects stay high.
    do_frame("t6", 2'd3, 2'd0, 2'd1, 8'd0, 8'h96, 8'h00, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
